// File: rtl/pixel_pack_fifo_if.sv
// ============================================================================
// Module      : pixel_pack_fifo_if
// Description : Bundle of pixel write, word read and status signals for the
//               pixel_pack_fifo. The master drives pixels, flush and read
//               requests; the slave (the FIFO) returns words and flags.
//               PIXEL_PACK_FIFO_STATS_EN adds level and drop_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_pack_fifo_if #(
  parameter int ADDR_W = 8
);
  logic        write_enable;
  logic [7:0]  write_data;
  logic        flush;
  logic        read_enable;
  logic [31:0] read_data;
  logic        data_valid;
  logic        empty;
  logic        afull;
  logic        full;
  logic        overflow;
`ifdef PIXEL_PACK_FIFO_STATS_EN
  logic [ADDR_W:0] level;
  logic [15:0]     drop_count;

  modport master (
    output write_enable, write_data, flush, read_enable,
    input  read_data, data_valid, empty, afull, full, overflow,
    input  level, drop_count
  );

  modport slave (
    input  write_enable, write_data, flush, read_enable,
    output read_data, data_valid, empty, afull, full, overflow,
    output level, drop_count
  );
`else
  modport master (
    output write_enable, write_data, flush, read_enable,
    input  read_data, data_valid, empty, afull, full, overflow
  );

  modport slave (
    input  write_enable, write_data, flush, read_enable,
    output read_data, data_valid, empty, afull, full, overflow
  );
`endif
endinterface

`default_nettype wire

// File: rtl/pixel_pack_fifo.sv
// ============================================================================
// Module      : pixel_pack_fifo
// Description : Packs four 8-bit pixels into a 32-bit word (pixel 0 in the
//               low byte) and buffers words in a synchronous FIFO. A flush
//               pulse commits a partial word with zero-filled upper lanes.
//               Status flags are registered from next-state occupancy.
//               Optional macro PIXEL_PACK_FIFO_STATS_EN adds the level and
//               drop_count outputs.
//               DEPTH must equal 2**ADDR_W; AFULL_LEVEL in 1..DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_pack_fifo #(
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int AFULL_LEVEL = 192
) (
  input  wire logic        clk,
  input  wire logic        reset,
  pixel_pack_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] c_afull = (ADDR_W+1)'(AFULL_LEVEL);

  // Pack register and word storage
  logic [23:0]       r_pack;
  logic [1:0]        r_idx;
  logic [31:0]       r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  // Registered outputs
  logic [31:0] r_read_data;
  logic        r_data_valid;
  logic        r_empty;
  logic        r_afull;
  logic        r_full;
  logic        r_overflow;

  // Per-cycle decisions
  logic            w_wr_ok;
  logic            w_wr_drop;
  logic            w_pending;
  logic            w_fl_drop;
  logic            w_commit;
  logic            w_rd_ok;
  logic [31:0]     w_word;
  logic [1:0]      w_idx_nxt;
  logic [ADDR_W:0] w_count_nxt;

  // The full flag alone gates the write path, even when a read frees a slot
  // in the same cycle.
  assign w_wr_ok   = bus.write_enable & ~r_full;
  assign w_wr_drop = bus.write_enable &  r_full;
  assign w_pending = (r_idx != 2'd0);
  assign w_fl_drop = bus.flush & r_full & w_pending;
  assign w_rd_ok   = bus.read_enable & ~r_empty;

  // A word is committed on the 4th byte, or on flush when at least one byte
  // (held or arriving this cycle) exists. Flush after a 4-byte commit in the
  // same cycle adds nothing because the same single commit covers both.
  assign w_commit = ~r_full &
                    ((w_wr_ok & (r_idx == 2'd3)) |
                     (bus.flush & (w_pending | w_wr_ok)));

  assign w_count_nxt = r_count + (ADDR_W+1)'(w_commit) - (ADDR_W+1)'(w_rd_ok);

  // Assemble the outgoing word: held lanes below the index, the incoming
  // byte at the index, zero above; stale held lanes are never exposed.
  always_comb begin
    w_word = 32'd0;
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < r_idx) begin
        w_word[8*i +: 8] = r_pack[8*i +: 8];
      end
    end
    if (w_wr_ok) begin
      w_word[{r_idx, 3'b000} +: 8] = bus.write_data;
    end
  end

  // Byte index advance; any commit or discarded partial restarts at lane 0.
  always_comb begin
    w_idx_nxt = r_idx;
    if (w_commit || w_fl_drop) begin
      w_idx_nxt = 2'd0;
    end else if (w_wr_ok) begin
      w_idx_nxt = r_idx + 2'd1;
    end
  end

  // Pack register: capture accepted bytes into their lane.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pack <= 24'd0;
      r_idx  <= 2'd0;
    end else begin
      r_idx <= w_idx_nxt;
      if (w_wr_ok) begin
        case (r_idx)
          2'd0:    r_pack[7:0]   <= bus.write_data;
          2'd1:    r_pack[15:8]  <= bus.write_data;
          2'd2:    r_pack[23:16] <= bus.write_data;
          default: r_pack        <= r_pack;
        endcase
      end
    end
  end

  // Word storage; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_wr_ptr] <= w_word;
    end
  end

  // Pointers, occupancy and flags derived from next-state occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_afull  <= 1'b0;
      r_full   <= 1'b0;
    end else begin
      if (w_commit) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_afull <= (w_count_nxt >= c_afull);
      r_full  <= (w_count_nxt == c_depth);
    end
  end

  // Read port: one-cycle latency, data held when no read is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_read_data  <= 32'd0;
      r_data_valid <= 1'b0;
    end else begin
      r_data_valid <= w_rd_ok;
      if (w_rd_ok) begin
        r_read_data <= r_mem[r_rd_ptr];
      end
    end
  end

  // Sticky overflow on any dropped pixel or dropped partial word.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_wr_drop || w_fl_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.data_valid = r_data_valid;
  assign bus.empty      = r_empty;
  assign bus.afull      = r_afull;
  assign bus.full       = r_full;
  assign bus.overflow   = r_overflow;

`ifdef PIXEL_PACK_FIFO_STATS_EN
  logic [15:0] r_drop_count;
  logic [1:0]  w_drops;
  logic [16:0] w_drop_sum;

  // A pixel and a partial word can both be dropped in one cycle.
  assign w_drops    = {1'b0, w_wr_drop} + {1'b0, w_fl_drop};
  assign w_drop_sum = {1'b0, r_drop_count} + {15'd0, w_drops};

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_count <= 16'd0;
    end else if (w_drop_sum[16]) begin
      r_drop_count <= 16'hFFFF;
    end else begin
      r_drop_count <= w_drop_sum[15:0];
    end
  end

  assign bus.level      = r_count;
  assign bus.drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: doc/pixel_pack_fifo.md
Name: pixel_pack_fifo

Overview:
- Per-camera pixel buffer placed between adc_controller (write side: 8-bit pixels, fifo_write_enable/fifo_write_data) and imager_apb_interface (read side: 32-bit words).
- Packs four consecutive pixels into one 32-bit word and stores words in a synchronous FIFO.
- Generates the empty/afull/full/overflow status and interrupt signals consumed by the APB interface and the MSS.
- Adds a flush input so a partial word at frame end is committed.

Parameters:
- ADDR_W, 8, log2 of FIFO depth in words.
- DEPTH, 256, FIFO depth in words. Must equal 2**ADDR_W.
- AFULL_LEVEL, 192, occupancy in words at or above which afull asserts. Range 1..DEPTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous active-high reset; clears all state.
- write_enable  in  1  pixel strobe from adc_controller; one pixel per cycle.
- write_data  in  8  pixel value.
- flush  in  1  single-cycle pulse, driven by frame_capture_done; commits a partial word.
- read_enable  in  1  word read request from the APB interface.
- read_data  out  32  word read out; pixel 0 in [7:0], pixel 3 in [31:24].
- data_valid  out  1  one-cycle pulse; read_data is valid.
- empty  out  1  FIFO holds zero words.
- afull  out  1  occupancy >= AFULL_LEVEL.
- full  out  1  occupancy == DEPTH.
- overflow  out  1  sticky; a pixel or flush was dropped.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: read_data=0, data_valid=0, empty=1, afull=0, full=0, overflow=0. Pack register, byte index, read/write pointers and occupancy are all cleared.
- Reset mid-operation discards the partial word and all stored words; data_valid is forced to 0 in the cycle after reset.
- Pack register: 24-bit holding register plus a 2-bit byte index (0..3).
- write_enable with full=0:
  - index<3: byte stored at lane index; index increments.
  - index==3: the word {write_data, held bytes} is committed to the FIFO at wr_ptr; index returns to 0.
- write_enable with full=1: byte discarded, pack register and index unchanged, overflow set to 1. overflow stays 1 until reset.
- flush with full=0:
  - Any write_enable byte in the same cycle is included first.
  - If the resulting byte count is 1..3, the word is committed with unused upper lanes = 0, and index returns to 0.
  - If the byte count is 0 (or a 4-byte word was committed that cycle), flush is a no-op.
- flush with full=1 and a pending partial word: partial word discarded, index=0, overflow=1.
- Read: read_enable at cycle N with empty=0 gives read_data = word at rd_ptr and data_valid=1 at N+1; rd_ptr then increments.
- read_enable with empty=1 is ignored: data_valid=0, read_data holds its last value, no error flag.
- Simultaneous commit and read: both proceed and occupancy is unchanged. This is legal when the FIFO is not full. When full, writes are dropped even if read_enable is high, because the full flag governs the write path.
- Pointers: ADDR_W bits, wrapping DEPTH-1 -> 0. Occupancy is an ADDR_W+1 bit counter.
- Flags are registered from the next-state occupancy, so they are valid in the same cycle as the commit/read result:
  - A commit at cycle N deasserts empty at N+1.
  - The read at N that empties the FIFO asserts empty at N+1.
- Write-to-read latency: the 4th byte at cycle N makes the word readable from N+1, with data_valid at N+2 at the earliest.

Optional Feature:
- Macro: PIXEL_PACK_FIFO_STATS_EN.
- Defined: adds output level [ADDR_W:0] (registered occupancy, reset 0).
- Defined: adds output drop_count [15:0], reset 0. It increments once per dropped pixel or dropped flush and saturates at 16'hFFFF.
- Undefined: neither port exists and no counter logic is synthesized; all other behaviour is identical.

Test Plan:
- Reset, then write pixels 0x11,0x22,0x33,0x44, then read_enable -> data_valid pulse one cycle after the read with read_data=0x44332211; empty returns to 1.
- Write 0xAA,0xBB, then flush -> one word 0x0000BBAA stored. A second flush with no bytes pending -> occupancy stays 1.
- Write 4*DEPTH pixels with no reads -> afull rises when occupancy reaches 192, full when it reaches 256. A 1025th pixel 0x5A -> overflow=1, and reading all 256 words shows 0x5A was never stored.
- With occupancy=1, read_enable high and a 4th byte committing in the same cycle -> occupancy stays 1, data_valid next cycle with the old word, then the new word is readable.
- read_enable on an empty FIFO -> data_valid stays 0 and read_data is unchanged. Pointer wrap: 300 write/read word pairs -> data is returned in order across the 255->0 wrap.
- Assert reset after 3 pixels and 10 words -> empty=1, full=0, afull=0, overflow=0. A new 4-pixel write then yields only the new word.
